spi_txn_sequencer: RTL

- Upstream controller for the 16-bit SPI master.
- Buffers outgoing words in a TX FIFO and runs multi-word transactions under a single chip select, with programmable CS setup, hold and idle-gap timing.
- Feeds the master one word per TX_DV/TX_Ready handshake and forwards each received word to the host.
- Owns CS_n, which the master itself does not drive.

---
 rtl/spi_txn_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: upstream controller for a 16-bit SPI master.
// Buffers TX words in a FIFO, frames multi-word transactions under one chip
// select with programmable setup/hold/idle timing, and forwards RX words.
//
// Master handshake: a word is handed over in the cycle where o_M_TX_DV=1,
// which only happens while i_M_TX_Ready=1 and the FIFO holds a word; the
// master drops ready afterwards. o_M_TX_Byte is only meaningful with o_M_TX_DV
// and reads 0 otherwise.
module spi_txn_sequencer #(
    parameter int MAX_WORDS     = 16,
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4,
    parameter int CS_IDLE_CLKS  = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Start,
    input  logic [$clog2(MAX_WORDS):0]    i_Word_Count,
    input  logic                          i_TX_Wr,
    input  logic [15:0]                   i_TX_Word,
    output logic                          o_TX_Full,
    output logic [$clog2(MAX_WORDS):0]    o_TX_Level,
    output logic                          o_Busy,
    output logic                          o_Done,
    output logic                          o_Err,
    output logic                          o_RX_DV,
    output logic [15:0]                   o_RX_Word,
    output logic [15:0]                   o_M_TX_Byte,
    output logic                          o_M_TX_DV,
    input  logic                          i_M_TX_Ready,
    input  logic                          i_M_RX_DV,
    input  logic [15:0]                   i_M_RX_Byte,
    output logic                          o_SPI_CS_n
);

    localparam int AW      = $clog2(MAX_WORDS);
    localparam int LW      = AW + 1;
    localparam int CNT_A   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int CNT_MAX = (CNT_A > CS_IDLE_CLKS) ? CNT_A : CS_IDLE_CLKS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_HOLD    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic [LW-1:0]   remaining_q, remaining_d;
    logic            cs_n_q, cs_n_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            rx_dv_q, rx_dv_d;
    logic [15:0]     rx_word_q, rx_word_d;

    logic [15:0]     mem_q [MAX_WORDS];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    logic            fifo_full, fifo_empty, push, pop, m_tx_dv, count_legal;

    assign fifo_full   = (level_q == LW'(MAX_WORDS));
    assign fifo_empty  = (level_q == '0);
    assign push        = i_TX_Wr && !fifo_full;
    assign count_legal = (i_Word_Count != '0) && (i_Word_Count <= LW'(MAX_WORDS));

    // FIFO pointer and occupancy bookkeeping; pushes while full are dropped
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge i_Clk) begin
        if (push) mem_q[wr_ptr_q] <= i_TX_Word;
    end

    // Transaction FSM: next state, counters, pulses and chip select
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        rx_dv_d     = 1'b0;
        rx_word_d   = rx_word_q;
        pop         = 1'b0;
        m_tx_dv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    if (count_legal) begin
                        state_d     = ST_SETUP;
                        remaining_d = i_Word_Count;
                        cnt_d       = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(CS_SETUP_CLKS - 1)) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (i_M_TX_Ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        m_tx_dv = 1'b1;
                        state_d = ST_WAIT_RX;
                    end else begin
                        // Underrun: abandon the remaining words but close out cleanly
                        err_d   = 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end
                end
            end
            ST_WAIT_RX: begin
                if (i_M_RX_DV) begin
                    rx_dv_d     = 1'b1;
                    rx_word_d   = i_M_RX_Byte;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LW'(1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end else begin
                        // Master still owes trailing clock edges; SEND re-waits on ready
                        state_d = ST_SEND;
                    end
                end
            end
            ST_HOLD: begin
                // Hold time starts from the first cycle the master reports ready
                if (armed_q || i_M_TX_Ready) begin
                    armed_d = 1'b1;
                    if (cnt_q == CW'(CS_HOLD_CLKS - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(CS_IDLE_CLKS - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_Start && (state_q != ST_IDLE)) err_d = 1'b1;
        cs_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    end

    // State and datapath registers; reset raises CS_n and empties the FIFO at once
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            remaining_q <= '0;
            cs_n_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rx_dv_q     <= 1'b0;
            rx_word_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            remaining_q <= remaining_d;
            cs_n_q      <= cs_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rx_dv_q     <= rx_dv_d;
            rx_word_q   <= rx_word_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    assign o_TX_Full   = fifo_full;
    assign o_TX_Level  = level_q;
    assign o_Busy      = (state_q != ST_IDLE);
    assign o_Done      = done_q;
    assign o_Err       = err_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Word   = rx_word_q;
    assign o_M_TX_DV   = m_tx_dv;
    assign o_M_TX_Byte = m_tx_dv ? mem_q[rd_ptr_q] : 16'h0000;
    assign o_SPI_CS_n  = cs_n_q;

endmodule
